// File: rtl/physics_frame_sequencer_pkg.sv
// Shared types and constants for the soft-body physics frame sequencer (package physics_pkg).
package physics_pkg;

  localparam int MATRIX_DIM      = 16;
  localparam int PIXELS          = MATRIX_DIM * MATRIX_DIM;
  localparam int PIX_W           = 8;
  localparam int TICK_CYCLES_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    SETTLE,
    RENDER,
    PUBLISH
  } seq_state_t;

  // Cycles from the tick cycle to the first frame_valid cycle.
  function automatic int frame_latency(input int substeps, input int settle_cycles);
    return substeps * (1 + settle_cycles) + PIXELS + 1;
  endfunction

endpackage

// File: rtl/physics_frame_sequencer_if.sv
// Particle-array and matrix-driver side signals of the frame sequencer.
interface physics_frame_sequencer_if;
  import physics_pkg::*;

  logic              step_en;
  logic              render_en;
  logic [PIX_W-1:0]  render_addr;
  logic              pixel_hit;
  logic [PIXELS-1:0] frame;
  logic              frame_valid;
  logic              frame_ready;

  modport master (
    output step_en, render_en, render_addr, frame, frame_valid,
    input  pixel_hit, frame_ready
  );

  modport slave (
    input  step_en, render_en, render_addr, frame, frame_valid,
    output pixel_hit, frame_ready
  );

endinterface

// File: rtl/physics_frame_sequencer_tick.sv
// Free-running frame pacing counter; tick is high for the last cycle of each period.
module frame_tick_gen #(
  parameter int TICK_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (count == CW'(TICK_CYCLES - 1)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == CW'(TICK_CYCLES - 1));

endmodule

// File: rtl/physics_frame_sequencer.sv
// Frame sequencer: particle substeps, 16x16 hit-test sweep, then frame hand-off to the driver.
// Define PHYS_SEQ_OVERRUN_EN to build the sticky tick-while-busy overrun flag.
module physics_frame_sequencer
  import physics_pkg::*;
#(
  parameter int TICK_CYCLES   = TICK_CYCLES_DEF,
  parameter int SUBSTEPS      = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        run,
  physics_frame_sequencer_if.master   bus,
  output logic                        busy,
  output logic [15:0]                 frame_count,
  output logic                        overrun
);

  if (SUBSTEPS < 1 || SUBSTEPS > 15) begin : g_bad_substeps
    $error("physics_frame_sequencer: SUBSTEPS must be 1..15");
  end
  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("physics_frame_sequencer: SETTLE_CYCLES must be 0..15");
  end
  if (TICK_CYCLES <= frame_latency(SUBSTEPS, SETTLE_CYCLES) + 1) begin : g_bad_tick
    $error("physics_frame_sequencer: TICK_CYCLES too short for one frame");
  end

  seq_state_t        state;
  logic              tick;
  logic [3:0]        substep;
  logic [3:0]        substep_nxt;
  logic [3:0]        settle_cnt;
  logic [PIXELS-1:0] shadow;
  logic              step_en;
  logic              render_en;
  logic [PIX_W-1:0]  render_addr;
  logic [PIXELS-1:0] frame;
  logic              frame_valid;

  frame_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign substep_nxt = substep + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      substep     <= '0;
      settle_cnt  <= '0;
      shadow      <= '0;
      step_en     <= 1'b0;
      render_en   <= 1'b0;
      render_addr <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      step_en <= 1'b0;
      case (state)
        IDLE: begin
          if (tick && run) begin
            state   <= STEP;
            step_en <= 1'b1;
            busy    <= 1'b1;
            substep <= '0;
          end
        end
        STEP: begin
          substep    <= substep_nxt;
          settle_cnt <= '0;
          if (SETTLE_CYCLES > 0) begin
            state <= SETTLE;
          end else if (substep_nxt < 4'(SUBSTEPS)) begin
            state   <= STEP;
            step_en <= 1'b1;
          end else begin
            state       <= RENDER;
            render_en   <= 1'b1;
            render_addr <= '0;
            shadow      <= '0;
          end
        end
        SETTLE: begin
          if (settle_cnt == 4'(SETTLE_CYCLES - 1)) begin
            if (substep < 4'(SUBSTEPS)) begin
              state   <= STEP;
              step_en <= 1'b1;
            end else begin
              state       <= RENDER;
              render_en   <= 1'b1;
              render_addr <= '0;
              shadow      <= '0;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        RENDER: begin
          shadow[render_addr] <= bus.pixel_hit;
          render_addr         <= render_addr + 1'b1;
          // The last pixel's hit is folded straight into the published frame.
          if (render_addr == PIX_W'(PIXELS - 1)) begin
            state       <= PUBLISH;
            render_en   <= 1'b0;
            frame       <= {bus.pixel_hit, shadow[PIXELS-2:0]};
            frame_valid <= 1'b1;
          end
        end
        PUBLISH: begin
          if (bus.frame_ready) begin
            state       <= IDLE;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            frame_count <= frame_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PHYS_SEQ_OVERRUN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (tick && (state != IDLE)) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

  assign bus.step_en     = step_en;
  assign bus.render_en   = render_en;
  assign bus.render_addr = render_addr;
  assign bus.frame       = frame;
  assign bus.frame_valid = frame_valid;

endmodule
